// File: rtl/video_tint_pkg.sv
// Shared types and helpers for the video_tint output stage: the RGB gain record, the
// power-on gain table contents and mono-to-wide pixel expansion.
package video_tint_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_gain_t;

  // Index 0 is the rightmost element: white, red, green, blue.
  localparam rgb_gain_t [3:0] DEFAULT_GAINS = {24'h0000FF, 24'h00FF00, 24'hFF0000, 24'hFFFFFF};

  localparam int unsigned MAX_PX_W = 32;

  function automatic rgb_gain_t default_gain(input int unsigned idx);
    if (idx < 4) begin
      return DEFAULT_GAINS[idx[1:0]];
    end
    return 24'hFFFFFF;
  endfunction

  // Widen by replicating the MSBs into the new low bits; assumes out_w <= 2*in_w.
  function automatic logic [MAX_PX_W-1:0] expand_px(input logic [MAX_PX_W-1:0] px,
                                                    input int unsigned in_w,
                                                    input int unsigned out_w);
    logic [MAX_PX_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_PX_W; i++) begin
      if (i < out_w) begin
        res[out_w-1-i] = px[in_w-1-(i % in_w)];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/video_tint_delay.sv
// ce-gated shift register used to keep timing and side-band bits aligned with pixels.
module video_tint_delay #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage_q [Depth];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else if (ce_i) begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Depth-1];

endmodule

// File: rtl/video_tint.sv
// Frame-synchronous colour-tint output stage: mono pixel times a writable per-tint RGB gain.
// Optional scanline dimming is enabled by defining VIDEO_TINT_SCANLINE_EN.
module video_tint
  import video_tint_pkg::*;
#(
  parameter int unsigned IN_W      = 8,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned NUM_TINTS = 4,
  parameter int unsigned PIPE      = 2,
  parameter int unsigned TINT_W    = (NUM_TINTS > 1) ? $clog2(NUM_TINTS) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ce_pix,
  input  logic [TINT_W-1:0] tint_sel,
  input  logic              scan_en,
  input  logic              pal_we,
  input  logic [TINT_W-1:0] pal_addr,
  input  logic [23:0]       pal_data,
  input  logic [IN_W-1:0]   video_in,
  input  logic              hblank_in,
  input  logic              vblank_in,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [OUT_W-1:0]  vga_r,
  output logic [OUT_W-1:0]  vga_g,
  output logic [OUT_W-1:0]  vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_de
);

  rgb_gain_t         gain_q [NUM_TINTS];
  logic [TINT_W-1:0] active_tint_q, tint_req, tint_use;
  logic              vs_prev_q, vs_rise;
  logic [OUT_W-1:0]  v1_q;
  rgb_gain_t         gain1_q;
  logic              blank1, par1, px_par, scan_on;
  logic [OUT_W-1:0]  r2_q, g2_q, b2_q, r2_d, g2_d, b2_d;
  logic [MAX_PX_W-1:0] px_exp;

  logic unused_px_hi;
  assign unused_px_hi = ^px_exp[MAX_PX_W-1:OUT_W];

  function automatic logic [OUT_W-1:0] scale(input logic [OUT_W-1:0] v, input logic [7:0] g);
    logic [OUT_W+8:0] p;
    p = {9'b0, v} * {{OUT_W{1'b0}}, ({1'b0, g} + 9'd1)};
    return OUT_W'(p >> 8);
  endfunction

  // Gain table: writes are visible from the first ce_pix after the write cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_TINTS; i++) begin
        gain_q[i] <= default_gain(i);
      end
    end else if (pal_we && (32'(pal_addr) < NUM_TINTS)) begin
      gain_q[pal_addr] <= rgb_gain_t'(pal_data);
    end
  end

  // The pixel at the vsync edge already uses the new tint, so the whole frame matches.
  assign vs_rise  = vsync_in & ~vs_prev_q;
  assign tint_req = (32'(tint_sel) < NUM_TINTS) ? tint_sel : '0;
  assign tint_use = vs_rise ? tint_req : active_tint_q;
  assign px_exp   = expand_px(32'(video_in), IN_W, OUT_W);

`ifdef VIDEO_TINT_SCANLINE_EN
  logic hs_prev_q, parity_q, parity_d, hs_rise;

  assign hs_rise = hsync_in & ~hs_prev_q;

  always_comb begin
    parity_d = parity_q;
    if (vs_rise) begin
      parity_d = 1'b0;
    end else if (hs_rise) begin
      parity_d = ~parity_q;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hs_prev_q <= 1'b0;
      parity_q  <= 1'b0;
    end else if (ce_pix) begin
      hs_prev_q <= hsync_in;
      parity_q  <= parity_d;
    end
  end

  assign px_par  = parity_d;
  assign scan_on = scan_en;
`else
  logic unused_scan_en;
  assign unused_scan_en = scan_en;
  assign px_par         = 1'b0;
  assign scan_on        = 1'b0;
`endif

  video_tint_delay #(
    .Width(2),
    .Depth(1)
  ) u_side_dly (
    .clk_i(clk_sys),
    .rst_i(reset),
    .ce_i (ce_pix),
    .d_i  ({hblank_in | vblank_in, px_par}),
    .q_o  ({blank1, par1})
  );

  always_comb begin
    r2_d = scale(v1_q, gain1_q.r);
    g2_d = scale(v1_q, gain1_q.g);
    b2_d = scale(v1_q, gain1_q.b);
    if (scan_on && par1) begin
      r2_d = r2_d >> 1;
      g2_d = g2_d >> 1;
      b2_d = b2_d >> 1;
    end
    if (blank1) begin
      r2_d = '0;
      g2_d = '0;
      b2_d = '0;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      active_tint_q <= '0;
      vs_prev_q     <= 1'b0;
      v1_q          <= '0;
      gain1_q       <= '0;
      r2_q          <= '0;
      g2_q          <= '0;
      b2_q          <= '0;
    end else if (ce_pix) begin
      vs_prev_q     <= vsync_in;
      active_tint_q <= tint_use;
      v1_q          <= px_exp[OUT_W-1:0];
      gain1_q       <= gain_q[tint_use];
      r2_q          <= r2_d;
      g2_q          <= g2_d;
      b2_q          <= b2_d;
    end
  end

  generate
    if (PIPE > 2) begin : g_tail
      video_tint_delay #(
        .Width(3 * OUT_W),
        .Depth(PIPE - 2)
      ) u_px_dly (
        .clk_i(clk_sys),
        .rst_i(reset),
        .ce_i (ce_pix),
        .d_i  ({r2_q, g2_q, b2_q}),
        .q_o  ({vga_r, vga_g, vga_b})
      );
    end else begin : g_no_tail
      assign vga_r = r2_q;
      assign vga_g = g2_q;
      assign vga_b = b2_q;
    end
  endgenerate

  video_tint_delay #(
    .Width(3),
    .Depth(PIPE)
  ) u_sync_dly (
    .clk_i(clk_sys),
    .rst_i(reset),
    .ce_i (ce_pix),
    .d_i  ({hsync_in, vsync_in, ~(hblank_in | vblank_in)}),
    .q_o  ({vga_hs, vga_vs, vga_de})
  );

endmodule

// File: tb/tb_video_tint.sv
// Directed bench for video_tint: default-parameter instance (a) plus an IN_W=4, NUM_TINTS=5,
// PIPE=3 instance (b) sharing the stimulus.
module tb_video_tint;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ce_pix = 1'b0;
  logic [2:0]  tint_sel = '0;
  logic        scan_en = 1'b0;
  logic        pal_we = 1'b0;
  logic [2:0]  pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic [7:0]  video_in = '0;
  logic        hblank_in = 1'b0, vblank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;

  logic [7:0] a_r, a_g, a_b, b_r, b_g, b_b;
  logic       a_hs, a_vs, a_de, b_hs, b_vs, b_de;

  int checks = 0;
  int errors = 0;

`ifdef VIDEO_TINT_SCANLINE_EN
  localparam logic [7:0] OddExp = 8'h7F;
`else
  localparam logic [7:0] OddExp = 8'hFE;
`endif

  always #5 clk_sys = ~clk_sys;

  video_tint u_dut_a (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .tint_sel (tint_sel[1:0]),
    .scan_en  (scan_en),
    .pal_we   (pal_we),
    .pal_addr (pal_addr[1:0]),
    .pal_data (pal_data),
    .video_in (video_in),
    .hblank_in(hblank_in),
    .vblank_in(vblank_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .vga_r    (a_r),
    .vga_g    (a_g),
    .vga_b    (a_b),
    .vga_hs   (a_hs),
    .vga_vs   (a_vs),
    .vga_de   (a_de)
  );

  video_tint #(
    .IN_W     (4),
    .OUT_W    (8),
    .NUM_TINTS(5),
    .PIPE     (3)
  ) u_dut_b (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .ce_pix   (ce_pix),
    .tint_sel (tint_sel),
    .scan_en  (scan_en),
    .pal_we   (pal_we),
    .pal_addr (pal_addr),
    .pal_data (pal_data),
    .video_in (video_in[7:4]),
    .hblank_in(hblank_in),
    .vblank_in(vblank_in),
    .hsync_in (hsync_in),
    .vsync_in (vsync_in),
    .vga_r    (b_r),
    .vga_g    (b_g),
    .vga_b    (b_b),
    .vga_hs   (b_hs),
    .vga_vs   (b_vs),
    .vga_de   (b_de)
  );

  typedef struct {
    logic [7:0] v;
    logic       hb, vb, hs, vs;
    logic [2:0] tint;
    logic [7:0] er, eg, eb;
    logic       ehs, evs, ede;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One pixel: ce_pix high for a single clock, then three idle clocks.
  task automatic px(input logic [7:0] v, input logic hb, input logic vb, input logic hs,
                    input logic vs, input logic we);
    @(negedge clk_sys);
    video_in  = v;
    hblank_in = hb;
    vblank_in = vb;
    hsync_in  = hs;
    vsync_in  = vs;
    pal_we    = we;
    ce_pix    = 1'b1;
    @(negedge clk_sys);
    ce_pix = 1'b0;
    pal_we = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic wr(input logic [2:0] a, input logic [23:0] d);
    @(negedge clk_sys);
    pal_we   = 1'b1;
    pal_addr = a;
    pal_data = d;
    @(negedge clk_sys);
    pal_we = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    vsync_in = 1'b0;
    hsync_in = 1'b0;
    reset    = 1'b1;
    repeat (2) @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    //        v      hb    vb    hs    vs    tint  r      g      b      hs    vs    de
    vecs[0]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h80, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[6]  = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1};
    vecs[7]  = '{8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 3'd1, 8'h80, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h40, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'hFF, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{8'h40, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h40, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{8'hC0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 8'h00, 8'h00, 8'hC0, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hC0, 1'b0, 1'b1, 1'b1};
    vecs[16] = '{8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1};

    repeat (3) @(negedge clk_sys);
    chk("reset_a", {a_r, a_g, a_b, a_hs, a_vs, a_de}, 32'h0);
    chk("reset_b", {b_r, b_g, b_b, b_hs, b_vs, b_de}, 32'h0);
    reset = 1'b0;

    // Table: with PIPE=2 the outputs after vector i belong to vector i-1.
    for (int i = 0; i < 17; i++) begin
      tint_sel = vecs[i].tint;
      px(vecs[i].v, vecs[i].hb, vecs[i].vb, vecs[i].hs, vecs[i].vs, 1'b0);
      chk($sformatf("vec%0d", i), {a_r, a_g, a_b, a_hs, a_vs, a_de},
          {vecs[i].er, vecs[i].eg, vecs[i].eb, vecs[i].ehs, vecs[i].evs, vecs[i].ede});
    end

    // Gain-table writes: idle-cycle write, then a write coincident with ce_pix.
    tint_sel = 3'd2;
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("tint2_default", {a_r, a_g, a_b}, 24'h00FF00);
    wr(3'd2, 24'h40FF00);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pal_write", {a_r, a_g, a_b}, 24'h40FF00);
    pal_addr = 3'd2;
    pal_data = 24'h102030;
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pal_same_ce_old", {a_r, a_g, a_b}, 24'h40FF00);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("pal_next_ce_new", {a_r, a_g, a_b}, 24'h102030);

    // Asynchronous reset between clock edges, mid-line.
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_a", {a_r, a_g, a_b, a_hs, a_vs, a_de}, 32'h0);
    chk("async_reset_b", {b_r, b_g, b_b, b_hs, b_vs, b_de}, 32'h0);
    @(negedge clk_sys);
    reset    = 1'b0;
    vsync_in = 1'b0;
    tint_sel = 3'd2;
    px(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_tint0", {a_r, a_g, a_b, a_de}, 25'h1010101);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    px(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("reset_table", {a_r, a_g, a_b}, 24'h00FF00);

    // Instance b: 4-bit input expansion, PIPE=3, fifth table entry and range limits.
    do_reset();
    tint_sel = 3'd0;
    px(8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_latency_hold", {b_r, b_g, b_b, b_de}, 25'h0);
    px(8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_expand", {b_r, b_g, b_b, b_de}, 25'h1555555);
    wr(3'd4, 24'h123456);
    wr(3'd5, 24'h000000);
    tint_sel = 3'd4;
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_entry4", {b_r, b_g, b_b}, 24'h123456);
    tint_sel = 3'd5;
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("b_tint_oob", {b_r, b_g, b_b}, 24'hFFFFFF);

    // Scanline dimming on odd lines (no effect unless the feature is built in).
    do_reset();
    tint_sel = 3'd0;
    scan_en  = 1'b1;
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scan_even0", {a_r, a_g, a_b}, 24'hFEFEFE);
    px(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scan_odd", {a_r, a_g, a_b}, {OddExp, OddExp, OddExp});
    px(8'hFE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    px(8'hFE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("scan_even2", {a_r, a_g, a_b}, 24'hFEFEFE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/video_tint.md
# video_tint

Parametrised colour-tint video output stage between the core's monochrome video generator and the emu-level VGA outputs. It replaces the fixed White/Red/Green/Blue noise-colour mux with a writable per-tint RGB gain table and a pipelined multiply. It is frame-synchronous: a tint change takes effect only at the next vertical sync, never mid-frame. Sync and blank signals are delayed to stay aligned with the pixel pipeline.

## Interface
- IN_W, 8: mono intensity width of `video_in`.
- OUT_W, 8: per-channel output width; legal range IN_W..2*IN_W.
- NUM_TINTS, 4: gain-table entries; TINT_W = max(1, $clog2(NUM_TINTS)).
- PIPE, 2: pixel latency in ce_pix enables; legal range 2..4.

- clk_sys  in  1  system/video clock, the only clock.
- reset  in  1  asynchronous, active-high.
- ce_pix  in  1  pixel enable; the whole pipeline advances only when high.
- tint_sel  in  TINT_W  requested tint, e.g. from status bits.
- scan_en  in  1  scanline dimming request.
- pal_we  in  1  gain-table write strobe, any clk_sys cycle.
- pal_addr  in  TINT_W  gain-table write index.
- pal_data  in  24  gains {R[23:16], G[15:8], B[7:0]}.
- video_in  in  IN_W  mono intensity.
- hblank_in, vblank_in, hsync_in, vsync_in  in  1 each  raw timing.
- vga_r, vga_g, vga_b  out  OUT_W each  tinted pixel.
- vga_hs, vga_vs, vga_de  out  1 each  delayed sync; vga_de = ~(hblank|vblank), delayed.

## Operation
- Expansion: v = {video_in, video_in[IN_W-1 -: OUT_W-IN_W]} (MSB replication; plain copy when OUT_W == IN_W).
- Channel math: out_c = (v * (g_c + 1)) >> 8, with a product width of OUT_W+9. g=0xFF gives exactly v; g=0x00 gives 0. Pixels inside blanking (hblank_in|vblank_in) are forced to 0.
- Gain table reset contents:
  - entry 0 = FF/FF/FF
  - entry 1 = FF/00/00
  - entry 2 = 00/FF/00
  - entry 3 = 00/00/FF
  - entries ≥4 = FF/FF/FF
- Table writes: a write with pal_addr ≥ NUM_TINTS is ignored. Written data is used from the first ce_pix strictly after the write cycle.
- Active tint:
  - `active_tint` resets to 0.
  - On a ce_pix at which vsync_in rises (registered previous value 0, current value 1), active_tint ← tint_sel.
  - tint_sel values ≥ NUM_TINTS are latched as 0.
- Pipeline stage 1 registers v, the blank flag, and the gains of active_tint. Stage 2 multiplies and registers the outputs. Stages 3..PIPE are pure delays. The sync/blank delay line has the same depth.

## Timing
- Latency is PIPE ce_pix enables from input to output, identical for pixel, sync, and de.
- No change occurs on cycles without ce_pix.
- The active_tint update and the first pixel of the new frame use the same ce_pix, so the tint applies to the whole frame after the vsync edge.
- Reset (asynchronous, at any point, including mid-line):
  - All outputs go to 0, vga_de = 0.
  - Pipeline, delay line, line counter, and edge registers are cleared.
  - Gain table returns to its defaults.
- Simultaneous pal_we and ce_pix: stage 1 captures the old gains; the new gains apply from the next ce_pix.

## Configuration
- VIDEO_TINT_SCANLINE_EN defined:
  - A 1-bit line parity toggles on each ce_pix where hsync_in rises and clears on each vsync_in rise.
  - When scan_en=1 and parity=1, the stage-2 result is shifted right by 1 (halved) on all three channels.
  - The parity is carried through the pipeline with the pixel.
- Not defined: the line counter is absent, scan_en is ignored, and output matches scan_en=0.

## Structure
- Package video_tint_pkg holds:
  - typedef rgb_gain_t (packed struct r, g, b, 8 bits each).
  - localparam DEFAULT_GAINS (4 × rgb_gain_t).
  - function expand_px for MSB replication.
- Sub-module video_tint_delay: a ce-gated shift register of parametrised width and depth, used for hs/vs/de/blank/parity.

## Test plan
- After reset, defaults, tint_sel=0, video_in=0x80 with blank low, one ce_pix per 4 clocks → after 2 enables r=g=b=0x80 with de=1; every output is 0 until then.
- tint_sel changed from 0 to 1 mid-frame → output stays 0x80/0x80/0x80 until the vsync rise, then 0x80/0x00/0x00 from the first pixel after the edge.
- Write pal_addr=2, pal_data=0x40FF00, with tint 2 active and video_in=0xFF → r=0x40, g=0xFF, b=0x00 from the ce_pix after the write. A write with pal_addr=5 (NUM_TINTS=4) leaves the table unchanged.
- IN_W=4, OUT_W=8, video_in=0xA → output channel 0xAA with the white tint.
- hblank_in high with video_in=0xFF → r=g=b=0, and vga_de=0 exactly PIPE enables later; hs/vs edges arrive PIPE enables after the input edges.
- With VIDEO_TINT_SCANLINE_EN and scan_en=1, video_in=0xFE → even lines give 0xFE, odd lines 0x7F. An asynchronous reset mid-line forces all outputs to 0 within the reset assertion and restores tint 0.
